// File: rtl/pifo_calendar_arbiter_pkg.sv
// Shared types and default widths for the PIFO calendar arbiter front end.
package pifo_calendar_arbiter_pkg;

    localparam int DEF_INFO_WIDTH        = 32;
    localparam int DEF_GLOBAL_WIDTH      = 32;
    localparam int DEF_BUFFER_ADDR_WIDTH = 12;
    localparam int DEF_COUNT_WIDTH       = 32;
    localparam int DEF_PEND_WIDTH        = 4;
    localparam int DEF_STAT_WIDTH        = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_ENQ,
        ISSUE_POP,
        SETTLE,
        SETTLE_POP
    } state_t;

    typedef enum logic {
        ENQ = 1'b0,
        POP = 1'b1
    } prio_t;

    function automatic prio_t other_side(prio_t p);
        return (p == ENQ) ? POP : ENQ;
    endfunction

endpackage

// File: rtl/pifo_pend_counter.sv
// Saturating count of outstanding dequeue requests; ready drops at saturation.
module pifo_pend_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             ready
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic inc_ok;

    assign ready  = (count != MAX);
    assign inc_ok = inc && ready;

    // dec is only raised by the owner while count is non-zero
    always_ff @(posedge clk) begin
        if (!rstn)
            count <= '0;
        else if (inc_ok && !dec)
            count <= count + 1'b1;
        else if (dec && !inc_ok)
            count <= count - 1'b1;
    end

endmodule

// File: rtl/pifo_calendar_arbiter.sv
// Arbitrates enqueue/dequeue traffic onto a PIFO calendar, one operation
// per three cycles, and returns pop results as a single-cycle pulse.
module pifo_calendar_arbiter
    import pifo_calendar_arbiter_pkg::*;
#(
    parameter int INFO_WIDTH        = DEF_INFO_WIDTH,
    parameter int GLOBAL_WIDTH      = DEF_GLOBAL_WIDTH,
    parameter int BUFFER_ADDR_WIDTH = DEF_BUFFER_ADDR_WIDTH,
    parameter int COUNT_WIDTH       = DEF_COUNT_WIDTH,
    parameter int PEND_WIDTH        = DEF_PEND_WIDTH,
    parameter int STAT_WIDTH        = DEF_STAT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         s_axis_enq_valid,
    output logic                         s_axis_enq_ready,
    input  logic [INFO_WIDTH-1:0]        s_axis_enq_info,
    input  logic [GLOBAL_WIDTH-1:0]      s_axis_enq_global,
    input  logic                         s_axis_deq_req,
    output logic                         s_axis_deq_req_ready,
    output logic                         m_axis_deq_valid,
    output logic [BUFFER_ADDR_WIDTH-1:0] m_axis_deq_addr,
    output logic [INFO_WIDTH-1:0]        m_axis_deq_top,
    output logic                         m_cal_insert_en,
    output logic                         m_cal_pop_en,
    output logic [INFO_WIDTH-1:0]        m_cal_pifo_info,
    output logic [GLOBAL_WIDTH-1:0]      m_cal_global_pifo,
    input  logic [INFO_WIDTH-1:0]        s_cal_top,
    input  logic [BUFFER_ADDR_WIDTH-1:0] s_cal_buffer_addr,
    input  logic                         s_cal_full,
    input  logic [COUNT_WIDTH-1:0]       s_cal_count,
    output logic [STAT_WIDTH-1:0]        m_stat_enq_cnt,
    output logic [STAT_WIDTH-1:0]        m_stat_deq_cnt,
    output logic                         m_busy
);

    state_t                state, next_state;
    prio_t                 prio;
    logic [PEND_WIDTH-1:0] pend_cnt;
    logic                  pop_elig, enq_elig;
    logic                  grant_pop, grant_enq;

    pifo_pend_counter #(.WIDTH(PEND_WIDTH)) u_pend (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (s_axis_deq_req),
        .dec   (state == ISSUE_POP),
        .count (pend_cnt),
        .ready (s_axis_deq_req_ready)
    );

    assign pop_elig = (pend_cnt != '0) && (s_cal_count != '0);
    assign enq_elig = s_axis_enq_valid && !s_cal_full;

    always_comb begin
        next_state = state;
        grant_pop  = 1'b0;
        grant_enq  = 1'b0;
        case (state)
            IDLE: begin
                if (pop_elig && (!enq_elig || prio == POP)) begin
                    grant_pop  = 1'b1;
                    next_state = ISSUE_POP;
                end else if (enq_elig) begin
                    grant_enq  = 1'b1;
                    next_state = ISSUE_ENQ;
                end
            end
            ISSUE_ENQ:  next_state = SETTLE;
            ISSUE_POP:  next_state = SETTLE_POP;
            SETTLE:     next_state = IDLE;
            SETTLE_POP: next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Ready mirrors the enqueue grant condition without looking at valid
    assign s_axis_enq_ready = (state == IDLE) && !s_cal_full && !(pop_elig && prio == POP);
    assign m_cal_insert_en  = (state == ISSUE_ENQ);
    assign m_cal_pop_en     = (state == ISSUE_POP);
    assign m_busy           = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            prio              <= POP;
            m_cal_pifo_info   <= '0;
            m_cal_global_pifo <= '0;
            m_stat_enq_cnt    <= '0;
            m_stat_deq_cnt    <= '0;
            m_axis_deq_valid  <= 1'b0;
            m_axis_deq_addr   <= '0;
            m_axis_deq_top    <= '0;
        end else begin
            if (state == IDLE && pop_elig && enq_elig)
                prio <= other_side(prio);
            if (grant_enq) begin
                m_cal_pifo_info   <= s_axis_enq_info;
                m_cal_global_pifo <= s_axis_enq_global;
            end
            if (state == ISSUE_ENQ)
                m_stat_enq_cnt <= m_stat_enq_cnt + 1'b1;
            if (state == ISSUE_POP)
                m_stat_deq_cnt <= m_stat_deq_cnt + 1'b1;
            m_axis_deq_valid <= (state == SETTLE_POP);
            if (state == SETTLE_POP) begin
                m_axis_deq_addr <= s_cal_buffer_addr;
                m_axis_deq_top  <= s_cal_top;
            end
        end
    end

endmodule

// File: tb/tb_pifo_calendar_arbiter.sv
// Directed bench: a per-cycle vector table for enqueue/pop/alternation,
// then hand sequences for saturation, full calendar and mid-pop reset.
module tb_pifo_calendar_arbiter;

    logic        clk;
    logic        rstn;
    logic        s_axis_enq_valid;
    logic        s_axis_enq_ready;
    logic [31:0] s_axis_enq_info;
    logic [31:0] s_axis_enq_global;
    logic        s_axis_deq_req;
    logic        s_axis_deq_req_ready;
    logic        m_axis_deq_valid;
    logic [11:0] m_axis_deq_addr;
    logic [31:0] m_axis_deq_top;
    logic        m_cal_insert_en;
    logic        m_cal_pop_en;
    logic [31:0] m_cal_pifo_info;
    logic [31:0] m_cal_global_pifo;
    logic [31:0] s_cal_top;
    logic [11:0] s_cal_buffer_addr;
    logic        s_cal_full;
    logic [31:0] s_cal_count;
    logic [31:0] m_stat_enq_cnt;
    logic [31:0] m_stat_deq_cnt;
    logic        m_busy;

    pifo_calendar_arbiter dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .s_axis_enq_valid     (s_axis_enq_valid),
        .s_axis_enq_ready     (s_axis_enq_ready),
        .s_axis_enq_info      (s_axis_enq_info),
        .s_axis_enq_global    (s_axis_enq_global),
        .s_axis_deq_req       (s_axis_deq_req),
        .s_axis_deq_req_ready (s_axis_deq_req_ready),
        .m_axis_deq_valid     (m_axis_deq_valid),
        .m_axis_deq_addr      (m_axis_deq_addr),
        .m_axis_deq_top       (m_axis_deq_top),
        .m_cal_insert_en      (m_cal_insert_en),
        .m_cal_pop_en         (m_cal_pop_en),
        .m_cal_pifo_info      (m_cal_pifo_info),
        .m_cal_global_pifo    (m_cal_global_pifo),
        .s_cal_top            (s_cal_top),
        .s_cal_buffer_addr    (s_cal_buffer_addr),
        .s_cal_full           (s_cal_full),
        .s_cal_count          (s_cal_count),
        .m_stat_enq_cnt       (m_stat_enq_cnt),
        .m_stat_deq_cnt       (m_stat_deq_cnt),
        .m_busy               (m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;
    int n_ins  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // strobe monitor: counts operations and enforces mutual exclusion
    always @(negedge clk) begin
        if (m_cal_pop_en)    n_pop++;
        if (m_cal_insert_en) n_ins++;
        if (rstn) chk("strobe_exclusive", {63'd0, m_cal_pop_en && m_cal_insert_en}, 64'd0);
    end

    // flags = {enq_ready, insert_en, pop_en, deq_valid, busy}
    typedef struct {
        logic        ev;
        logic [31:0] info;
        logic        dq;
        logic [31:0] cnt;
        logic [4:0]  flags;
        logic [31:0] minfo;
        logic [31:0] ecnt;
        logic [31:0] dcnt;
        logic [11:0] addr;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(logic ev, logic [31:0] info, logic dq, logic [31:0] cnt,
                                logic [4:0] flags, logic [31:0] minfo, logic [31:0] ecnt,
                                logic [31:0] dcnt, logic [11:0] addr);
        vec_t v;
        v.ev = ev; v.info = info; v.dq = dq; v.cnt = cnt; v.flags = flags;
        v.minfo = minfo; v.ecnt = ecnt; v.dcnt = dcnt; v.addr = addr;
        return v;
    endfunction

    task automatic drive_idle();
        s_axis_enq_valid  = 1'b0;
        s_axis_enq_info   = '0;
        s_axis_enq_global = '0;
        s_axis_deq_req    = 1'b0;
        s_cal_top         = '0;
        s_cal_buffer_addr = '0;
        s_cal_full        = 1'b0;
        s_cal_count       = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        logic found;
        rstn = 1'b0;
        drive_idle();

        tbl[0]  = mk(1'b0, 32'h00, 1'b0, 32'd0, 5'b10000, 32'h00, 32'd0, 32'd0, 12'h000);
        tbl[1]  = mk(1'b1, 32'h05, 1'b0, 32'd0, 5'b10000, 32'h00, 32'd0, 32'd0, 12'h000);
        tbl[2]  = mk(1'b0, 32'h00, 1'b0, 32'd0, 5'b01001, 32'h05, 32'd0, 32'd0, 12'h000);
        tbl[3]  = mk(1'b0, 32'h00, 1'b0, 32'd0, 5'b00001, 32'h05, 32'd1, 32'd0, 12'h000);
        tbl[4]  = mk(1'b0, 32'h00, 1'b1, 32'd3, 5'b10000, 32'h05, 32'd1, 32'd0, 12'h000);
        tbl[5]  = mk(1'b0, 32'h00, 1'b0, 32'd3, 5'b00000, 32'h05, 32'd1, 32'd0, 12'h000);
        tbl[6]  = mk(1'b0, 32'h00, 1'b0, 32'd3, 5'b00101, 32'h05, 32'd1, 32'd0, 12'h000);
        tbl[7]  = mk(1'b0, 32'h00, 1'b0, 32'd3, 5'b00001, 32'h05, 32'd1, 32'd1, 12'h000);
        tbl[8]  = mk(1'b0, 32'h00, 1'b0, 32'd3, 5'b10010, 32'h05, 32'd1, 32'd1, 12'h0A3);
        tbl[9]  = mk(1'b0, 32'h00, 1'b1, 32'd0, 5'b10000, 32'h05, 32'd1, 32'd1, 12'h0A3);
        tbl[10] = mk(1'b0, 32'h00, 1'b1, 32'd0, 5'b10000, 32'h05, 32'd1, 32'd1, 12'h0A3);
        tbl[11] = mk(1'b0, 32'h00, 1'b1, 32'd0, 5'b10000, 32'h05, 32'd1, 32'd1, 12'h0A3);
        tbl[12] = mk(1'b0, 32'h00, 1'b1, 32'd0, 5'b10000, 32'h05, 32'd1, 32'd1, 12'h0A3);
        tbl[13] = mk(1'b1, 32'h21, 1'b0, 32'd3, 5'b00000, 32'h05, 32'd1, 32'd1, 12'h0A3);
        tbl[14] = mk(1'b1, 32'h21, 1'b0, 32'd3, 5'b00101, 32'h05, 32'd1, 32'd1, 12'h0A3);
        tbl[15] = mk(1'b1, 32'h21, 1'b0, 32'd3, 5'b00001, 32'h05, 32'd1, 32'd2, 12'h0A3);
        tbl[16] = mk(1'b1, 32'h21, 1'b0, 32'd3, 5'b10010, 32'h05, 32'd1, 32'd2, 12'h0A3);
        tbl[17] = mk(1'b1, 32'h22, 1'b0, 32'd3, 5'b01001, 32'h21, 32'd1, 32'd2, 12'h0A3);
        tbl[18] = mk(1'b1, 32'h22, 1'b0, 32'd3, 5'b00001, 32'h21, 32'd2, 32'd2, 12'h0A3);
        tbl[19] = mk(1'b1, 32'h22, 1'b0, 32'd3, 5'b00000, 32'h21, 32'd2, 32'd2, 12'h0A3);
        tbl[20] = mk(1'b1, 32'h22, 1'b0, 32'd3, 5'b00101, 32'h21, 32'd2, 32'd2, 12'h0A3);
        tbl[21] = mk(1'b1, 32'h22, 1'b0, 32'd3, 5'b00001, 32'h21, 32'd2, 32'd3, 12'h0A3);
        tbl[22] = mk(1'b1, 32'h22, 1'b0, 32'd3, 5'b10010, 32'h21, 32'd2, 32'd3, 12'h0A3);
        tbl[23] = mk(1'b0, 32'h00, 1'b0, 32'd3, 5'b01001, 32'h22, 32'd2, 32'd3, 12'h0A3);
        tbl[24] = mk(1'b0, 32'h00, 1'b0, 32'd3, 5'b00001, 32'h22, 32'd3, 32'd3, 12'h0A3);

        // reset state
        do_reset();
        chk("rst deq_req_ready", {63'd0, s_axis_deq_req_ready}, 64'd1);
        chk("rst global",        {32'd0, m_cal_global_pifo},    64'd0);
        chk("rst deq_top",       {32'd0, m_axis_deq_top},       64'd0);

        // vector table: enqueue, single pop, POP/ENQ alternation
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            s_axis_enq_valid  = tbl[i].ev;
            s_axis_enq_info   = tbl[i].info;
            s_axis_enq_global = 32'h10;
            s_axis_deq_req    = tbl[i].dq;
            s_cal_count       = tbl[i].cnt;
            s_cal_buffer_addr = 12'h0A3;
            s_cal_top         = 32'h77;
            #1;
            chk($sformatf("r%0d enq_ready", i), {63'd0, s_axis_enq_ready}, {63'd0, tbl[i].flags[4]});
            chk($sformatf("r%0d insert_en", i), {63'd0, m_cal_insert_en},  {63'd0, tbl[i].flags[3]});
            chk($sformatf("r%0d pop_en", i),    {63'd0, m_cal_pop_en},     {63'd0, tbl[i].flags[2]});
            chk($sformatf("r%0d deq_valid", i), {63'd0, m_axis_deq_valid}, {63'd0, tbl[i].flags[1]});
            chk($sformatf("r%0d busy", i),      {63'd0, m_busy},           {63'd0, tbl[i].flags[0]});
            chk($sformatf("r%0d cal_info", i),  {32'd0, m_cal_pifo_info},  {32'd0, tbl[i].minfo});
            chk($sformatf("r%0d enq_cnt", i),   {32'd0, m_stat_enq_cnt},   {32'd0, tbl[i].ecnt});
            chk($sformatf("r%0d deq_cnt", i),   {32'd0, m_stat_deq_cnt},   {32'd0, tbl[i].dcnt});
            chk($sformatf("r%0d deq_addr", i),  {52'd0, m_axis_deq_addr},  {52'd0, tbl[i].addr});
            chk($sformatf("r%0d deq_top", i),   {32'd0, m_axis_deq_top},
                (tbl[i].addr != 12'h0) ? 64'h77 : 64'h0);
        end
        chk("global latched", {32'd0, m_cal_global_pifo}, 64'h10);

        // saturation on an empty calendar, then a single insert releases one pop
        do_reset();
        n_pop = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s_axis_deq_req = 1'b1;
        end
        @(negedge clk);
        s_axis_deq_req = 1'b0;
        #1;
        chk("sat deq_req_ready", {63'd0, s_axis_deq_req_ready}, 64'd0);
        chk("sat no pop",        64'(n_pop), 64'd0);
        @(negedge clk);
        s_axis_enq_valid = 1'b1;
        s_axis_enq_info  = 32'h9;
        #1;
        chk("sat enq_ready", {63'd0, s_axis_enq_ready}, 64'd1);
        @(negedge clk);
        s_axis_enq_valid = 1'b0;
        #1;
        chk("sat insert_en", {63'd0, m_cal_insert_en}, 64'd1);
        @(negedge clk);
        s_cal_count = 32'd1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("sat pop_en", {63'd0, m_cal_pop_en}, 64'd1);
        @(negedge clk);
        s_cal_count = 32'd0;
        repeat (8) @(negedge clk);
        #1;
        chk("sat one pop",       64'(n_pop), 64'd1);
        chk("sat ready again",   {63'd0, s_axis_deq_req_ready}, 64'd1);
        n_pop = 0;
        s_cal_count = 32'd100;
        repeat (60) @(negedge clk);
        #1;
        chk("sat remaining 14 pops", 64'(n_pop), 64'd14);

        // calendar full: enqueue stalls, pops still go
        do_reset();
        n_pop = 0;
        n_ins = 0;
        s_cal_full       = 1'b1;
        s_axis_enq_valid = 1'b1;
        s_axis_enq_info  = 32'h44;
        s_cal_count      = 32'd2;
        #1;
        chk("full enq_ready", {63'd0, s_axis_enq_ready}, 64'd0);
        @(negedge clk);
        s_axis_deq_req = 1'b1;
        @(negedge clk);
        s_axis_deq_req = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("full no insert", 64'(n_ins), 64'd0);
        chk("full one pop",   64'(n_pop), 64'd1);

        // reset during SETTLE_POP drops the in-flight result
        do_reset();
        s_cal_count       = 32'd2;
        s_cal_buffer_addr = 12'h155;
        s_cal_top         = 32'h99;
        @(negedge clk);
        s_axis_deq_req = 1'b1;
        @(negedge clk);
        s_axis_deq_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            #1;
            if (m_cal_pop_en) found = 1'b1;
        end
        chk("rstpop pop issued", {63'd0, found}, 64'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rstpop deq_cnt before", {32'd0, m_stat_deq_cnt}, 64'd1);
        chk("rstpop busy before",    {63'd0, m_busy},         64'd1);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rstpop deq_valid c%0d", k), {63'd0, m_axis_deq_valid}, 64'd0);
            @(negedge clk);
        end
        #1;
        chk("rstpop deq_cnt",  {32'd0, m_stat_deq_cnt},  64'd0);
        chk("rstpop enq_cnt",  {32'd0, m_stat_enq_cnt},  64'd0);
        chk("rstpop deq_addr", {52'd0, m_axis_deq_addr}, 64'd0);
        chk("rstpop busy",     {63'd0, m_busy},          64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pifo_calendar_arbiter.md
Name: pifo_calendar_arbiter

Overview:
Sequencing front end for pifo_calendar_demo.
- Arbitrates between an enqueue requester (valid/ready) and a dequeue requester (request pulses queued in a pending counter).
- Issues one-cycle insert_en/pop_en strobes to the calendar and waits for the calendar flags to settle before the next decision.
- Returns pop results as a one-cycle valid pulse and keeps wrap-around statistics counters.

Parameters:
INFO_WIDTH, 32, width of opaque pifo info word (calendar pifo_info_root)
GLOBAL_WIDTH, 32, width of global pifo word passed to the calendar
BUFFER_ADDR_WIDTH, 12, width of buffer address returned on pop
COUNT_WIDTH, 32, width of calendar occupancy count
PEND_WIDTH, 4, width of pending-dequeue counter (max 2^PEND_WIDTH-1)
STAT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock
rstn  in  1  reset; one clock, synchronous, active-low
s_axis_enq_valid  in  1  enqueue request valid
s_axis_enq_ready  out  1  enqueue accepted when valid&ready
s_axis_enq_info  in  INFO_WIDTH  pifo info to insert
s_axis_enq_global  in  GLOBAL_WIDTH  global pifo word for this insert
s_axis_deq_req  in  1  one dequeue request per high cycle
s_axis_deq_req_ready  out  1  pending counter not saturated
m_axis_deq_valid  out  1  one-cycle pop-result pulse
m_axis_deq_addr  out  BUFFER_ADDR_WIDTH  popped buffer address
m_axis_deq_top  out  INFO_WIDTH  calendar top captured with pop result
m_cal_insert_en  out  1  to calendar s_axis_insert_en
m_cal_pop_en  out  1  to calendar s_axis_pop_en
m_cal_pifo_info  out  INFO_WIDTH  to calendar s_axis_pifo_info_root
m_cal_global_pifo  out  GLOBAL_WIDTH  to calendar s_axis_global_pifo
s_cal_top  in  INFO_WIDTH  calendar m_axis_pifo_calendar_top
s_cal_buffer_addr  in  BUFFER_ADDR_WIDTH  calendar m_axis_buffer_addr
s_cal_full  in  1  calendar full flag
s_cal_count  in  COUNT_WIDTH  calendar occupancy
m_stat_enq_cnt  out  STAT_WIDTH  inserts issued, wraps
m_stat_deq_cnt  out  STAT_WIDTH  pops issued, wraps
m_busy  out  1  state != IDLE

Behaviour:
Reset (rstn=0 at a clk edge):
- state=IDLE, prio=POP, pend_cnt=0.
- All strobes 0; m_axis_deq_valid=0; m_axis_deq_addr=0; m_axis_deq_top=0; m_cal_pifo_info=0; m_cal_global_pifo=0.
- Both statistics counters = 0.
- Reset mid-operation discards any in-flight pop result; no deq_valid is emitted for it.

Eligibility in IDLE:
- pop_elig = pend_cnt!=0 && s_cal_count!=0.
- enq_elig = s_axis_enq_valid && !s_cal_full.

Arbitration:
- Only one eligible: grant it.
- Both eligible: grant prio, then flip prio to the other side.
- Non-conflict grants leave prio unchanged.

s_axis_enq_ready = (state==IDLE) && !s_cal_full && !(pop_elig && prio==POP). It does not depend on s_axis_enq_valid.

FSM (registered):
- IDLE -> ISSUE_ENQ on enq grant. s_axis_enq_info/global are latched into m_cal_pifo_info/m_cal_global_pifo.
- IDLE -> ISSUE_POP on pop grant.
- ISSUE_ENQ (1 cycle): m_cal_insert_en=1; m_stat_enq_cnt+1; -> SETTLE.
- ISSUE_POP (1 cycle): m_cal_pop_en=1; m_stat_deq_cnt+1; pend_cnt-1; -> SETTLE_POP.
- SETTLE (1 cycle): no strobes; -> IDLE. Calendar flags/count are valid again in IDLE.
- SETTLE_POP (1 cycle): register s_cal_buffer_addr and s_cal_top into the deq outputs; -> IDLE.
- m_axis_deq_valid=1 in the cycle after SETTLE_POP only.

Latency and throughput:
- Enqueue accepted in IDLE cycle T: insert_en at T+1; next grant possible at T+3.
- Pop granted at T: pop_en at T+1; deq_valid at T+3.
- Maximum one calendar operation per 3 cycles.

Pending-dequeue counter:
- pend_cnt +1 on s_axis_deq_req && s_axis_deq_req_ready.
- Simultaneous increment and ISSUE_POP decrement leaves it unchanged.
- Saturates at 2^PEND_WIDTH-1; s_axis_deq_req_ready=0 there, and requests in that state are ignored.
- Requests wait while the calendar is empty (count==0); no pop is issued on an empty calendar.
- Calendar full: enqueue stalls (ready=0); pops proceed.

Strobe rule: insert_en and pop_en are never high in the same cycle.

Counters: statistics counters wrap modulo 2^STAT_WIDTH.

Decomposition:
- Package pifo_calendar_arbiter_pkg: FSM state enum (IDLE, ISSUE_ENQ, ISSUE_POP, SETTLE, SETTLE_POP), prio encoding (ENQ=0, POP=1), default width constants.
- One sub-module: pifo_pend_counter (saturating up/down counter with ready output).
- Arbiter and FSM stay in the top module.

Test Plan:
1. Reset then idle -> all outputs 0, enq_ready=1 (calendar empty, not full), m_busy=0.
2. Enqueue info=0x0000_0005, global=0x10 at cycle T -> insert_en=1 at T+1 with m_cal_pifo_info=0x5; m_stat_enq_cnt=1; enq_ready=0 during T+1..T+2.
3. Calendar count=3, one deq_req -> pop_en 2 cycles later; deq_valid=1 for exactly one cycle, 3 cycles after grant, with deq_addr = calendar buffer_addr (e.g. 0x0A3).
4. Enq valid held and pend_cnt=4 with count>0 -> grants alternate POP, ENQ, POP, ENQ; never both strobes in one cycle.
5. Calendar empty, 20 deq_req pulses -> pend_cnt saturates at 15, deq_req_ready=0, no pop_en; after one insert -> exactly one pop, pend_cnt=14.
6. s_cal_full=1 with enq valid -> enq_ready=0, no insert_en. rstn=0 during SETTLE_POP -> no deq_valid, all counters 0.
